// File: rtl/uart_cmd_initiator.sv
// Host-side command initiator: serializes (cmd, addr, value) into a byte frame for a UART TX
// stream and, for read commands, reassembles the response from a UART RX stream with timeout.
`timescale 1ns/1ps
module uart_cmd_initiator #(
  parameter int unsigned            WORD_WIDTH     = 8,
  parameter int unsigned            VALUE_WORDS    = 4,
  parameter bit                     LITTLE_ENDIAN  = 1'b0,
  parameter logic [WORD_WIDTH-1:0]  CMD_READ       = 'h01,
  parameter int unsigned            TIMEOUT_CYCLES = 1000000
) (
  input  logic                              clk,
  input  logic                              i_reset_n,
  input  logic                              i_start,
  input  logic [WORD_WIDTH-1:0]             i_cmd,
  input  logic [WORD_WIDTH-1:0]             i_addr,
  input  logic [WORD_WIDTH*VALUE_WORDS-1:0] i_value,
  output logic                              o_busy,
  output logic [WORD_WIDTH-1:0]             o_tx_data,
  output logic                              o_tx_dv,
  input  logic                              i_tx_ready,
  input  logic [WORD_WIDTH-1:0]             i_rx_data,
  input  logic                              i_rx_dv,
  output logic [WORD_WIDTH*VALUE_WORDS-1:0] o_r_value,
  output logic                              o_r_valid,
  output logic                              o_done,
  output logic                              o_timeout
);

  localparam int unsigned NumBytes = VALUE_WORDS + 2;
  localparam int unsigned FrameW   = NumBytes * WORD_WIDTH;
  localparam int unsigned ValueW   = VALUE_WORDS * WORD_WIDTH;
  localparam int unsigned IdxW     = $clog2(NumBytes + 1);
  localparam int unsigned RxIdxW   = $clog2(VALUE_WORDS + 1);
  localparam int unsigned CntW     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSend, StWaitResp, StDone} state_e;

  state_e                state_q, state_d;
  // Frame held MS-byte-first as {cmd, addr, value}; endianness only changes the read order.
  logic [FrameW-1:0]     frame_q, frame_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [RxIdxW-1:0]     rx_idx_q, rx_idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  rx_dv_q;
  logic [WORD_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [ValueW-1:0]     r_value_q, r_value_d;
  logic                  r_ok_q, r_ok_d;
  logic                  timeout_q, timeout_d;

  logic                  rx_edge;
  logic                  is_read;
  logic [WORD_WIDTH-1:0] cur_byte;
  int unsigned           tx_sel;
  int unsigned           rx_sel;

  assign rx_edge = i_rx_dv & ~rx_dv_q;
  assign is_read = (frame_q[FrameW-1 -: WORD_WIDTH] == CMD_READ);

  // Byte/word position selection for the current TX byte and the next RX word.
  always_comb begin
    tx_sel   = LITTLE_ENDIAN ? 32'(idx_q) : (NumBytes - 1 - 32'(idx_q));
    rx_sel   = LITTLE_ENDIAN ? 32'(rx_idx_q) : (VALUE_WORDS - 1 - 32'(rx_idx_q));
    cur_byte = frame_q[tx_sel*WORD_WIDTH +: WORD_WIDTH];
  end

  // Next-state logic and TX strobe/data outputs.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    rx_idx_d  = rx_idx_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    r_value_d = r_value_q;
    r_ok_d    = r_ok_q;
    timeout_d = timeout_q;
    o_tx_dv   = 1'b0;
    o_tx_data = tx_data_q;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          frame_d   = {i_cmd, i_addr, i_value};
          timeout_d = 1'b0;
          r_ok_d    = 1'b0;
          idx_d     = '0;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (i_tx_ready) begin
          o_tx_dv   = 1'b1;
          o_tx_data = cur_byte;
          tx_data_d = cur_byte;
          if (idx_q == IdxW'(NumBytes - 1)) begin
            idx_d    = '0;
            rx_idx_d = '0;
            cnt_d    = '0;
            state_d  = is_read ? StWaitResp : StDone;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StWaitResp: begin
        // A byte arriving on the timeout cycle still counts.
        if (rx_edge) begin
          r_value_d[rx_sel*WORD_WIDTH +: WORD_WIDTH] = i_rx_data;
          cnt_d = '0;
          if (rx_idx_q == RxIdxW'(VALUE_WORDS - 1)) begin
            r_ok_d  = 1'b1;
            state_d = StDone;
          end else begin
            rx_idx_d = rx_idx_q + RxIdxW'(1);
          end
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          cnt_d     = CntW'(TIMEOUT_CYCLES);
          timeout_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      idx_q     <= '0;
      rx_idx_q  <= '0;
      cnt_q     <= '0;
      rx_dv_q   <= 1'b0;
      tx_data_q <= '0;
      r_value_q <= '0;
      r_ok_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      idx_q     <= idx_d;
      rx_idx_q  <= rx_idx_d;
      cnt_q     <= cnt_d;
      rx_dv_q   <= i_rx_dv;
      tx_data_q <= tx_data_d;
      r_value_q <= r_value_d;
      r_ok_q    <= r_ok_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_busy    = (state_q != StIdle);
  assign o_done    = (state_q == StDone);
  assign o_r_valid = (state_q == StDone) && r_ok_q;
  assign o_r_value = r_value_q;
  assign o_timeout = timeout_q;

endmodule
